// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector: run-time pattern/length/overlap,
// input-valid qualifier, registered match pulse and saturating match counter.
module seq_det_prog #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b0000_1011,
  parameter int unsigned          DEF_LEN     = 4,
  parameter bit                   DEF_OVERLAP = 1'b1,
  localparam int unsigned         LW          = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LW-1:0]      fill
);

  localparam logic [LW-1:0] MAX_L     = LW'(MAX_LEN);
  localparam logic [LW-1:0] DEF_LEN_L = LW'((DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ov_q, ov_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LW-1:0]      eff_len;
  logic [MAX_LEN-1:0] hist_sh;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  always_comb begin
    eff_len  = (cfg_len > MAX_L) ? MAX_L : cfg_len;
    hist_sh  = {hist_q[MAX_LEN-2:0], in};
    fill_inc = (fill_q >= MAX_L) ? MAX_L : fill_q + LW'(1);

    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len_q);
    end

    // Compare against the post-shift history so the pulse follows the final bit's edge.
    hit = (len_q != '0) && (fill_inc >= len_q) && (((hist_sh ^ pat_q) & mask) == '0);

    pat_d  = pat_q;
    len_d  = len_q;
    ov_d   = ov_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = eff_len;
      ov_d   = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_sh;
      fill_d = (hit && !ov_q) ? '0 : fill_inc;
      out_d  = hit;
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pat_q  <= DEF_PATTERN;
      len_q  <= DEF_LEN_L;
      ov_q   <= DEF_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ov_q   <= ov_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: default 8-bit counter instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation behaviour.
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       out, out2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [3:0] fill, fill2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_det_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out), .match_cnt(match_cnt), .fill(fill)
  );

  seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out2), .match_cnt(match_cnt2), .fill(fill2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in       = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in       = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic clr);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cnt_clr     = clr;
    tick();
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  logic [8:0] seq9;
  logic [8:0] exp9;
  logic [6:0] seq7;
  logic [6:0] exp7;
  logic [7:0] seq8;

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    nrst = 1'b1;

    // default config 1011 / len 4 / overlap
    seq9 = 9'b101101011;
    exp9 = 9'b000100001;
    for (int i = 8; i >= 0; i--) begin
      send(seq9[i]);
      chk("def_out", 32'(out), 32'(exp9[i]));
    end
    chk("def_cnt", 32'(match_cnt), 32'd2);
    chk("def_fill", 32'(fill), 32'd8);
    tick();
    chk("idle_out", 32'(out), 32'd0);

    // explicit load, overlap on
    in_valid = 1'b1;
    in       = 1'b1;
    load(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    chk("load_out", 32'(out), 32'd0);
    chk("load_fill", 32'(fill), 32'd0);
    chk("load_clr", 32'(match_cnt), 32'd0);
    seq7 = 7'b1011011;
    exp7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      send(seq7[i]);
      chk("ov1_out", 32'(out), 32'(exp7[i]));
    end
    chk("ov1_cnt", 32'(match_cnt), 32'd2);

    // overlap off, same stream
    load(8'b0000_1011, 4'd4, 1'b0, 1'b1);
    exp7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      send(seq7[i]);
      chk("ov0_out", 32'(out), 32'(exp7[i]));
      if (i == 3) chk("ov0_fill0", 32'(fill), 32'd0);
    end
    chk("ov0_cnt", 32'(match_cnt), 32'd1);
    chk("ov0_fill", 32'(fill), 32'd3);

    // in_valid gaps
    load(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    send(1'b1); chk("gap_b1", 32'(out), 32'd0);
    gap();      chk("gap_g1", 32'(out), 32'd0);
    send(1'b0); chk("gap_b2", 32'(out), 32'd0);
    gap();      chk("gap_g2", 32'(out), 32'd0);
    gap();      chk("gap_g3", 32'(out), 32'd0);
    send(1'b1); chk("gap_b3", 32'(out), 32'd0);
    gap();      chk("gap_g4", 32'(out), 32'd0);
    chk("gap_fill", 32'(fill), 32'd3);
    send(1'b1); chk("gap_b4", 32'(out), 32'd1);
    gap();      chk("gap_g5", 32'(out), 32'd0);
    chk("gap_cnt", 32'(match_cnt), 32'd1);

    // counter saturation on the 2-bit instance
    load(8'b0000_0011, 4'd2, 1'b1, 1'b1);
    chk("sat_clr", 32'(match_cnt2), 32'd0);
    send(1'b1);
    chk("sat_first", 32'(out2), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      send(1'b1);
      chk("sat_out", 32'(out2), 32'd1);
      chk("sat_cnt", 32'(match_cnt2), 32'((k > 3) ? 3 : k));
    end
    chk("sat_cnt8", 32'(match_cnt), 32'd5);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    chk("clr_win_out", 32'(out2), 32'd1);
    chk("clr_win_cnt2", 32'(match_cnt2), 32'd0);
    chk("clr_win_cnt", 32'(match_cnt), 32'd0);

    // cfg_load mid-pattern discards partial match and ignores in_valid
    load(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    send(1'b1); send(1'b0); send(1'b1);
    in_valid = 1'b1;
    in       = 1'b1;
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0);
    chk("mid_load_out", 32'(out), 32'd0);
    chk("mid_load_fill", 32'(fill), 32'd0);
    send(1'b1); chk("mid_load_next", 32'(out), 32'd0);
    send(1'b0); send(1'b1);
    send(1'b1); chk("mid_load_fresh", 32'(out), 32'd1);

    // reset mid-pattern
    load(8'b1111_0000, 4'd8, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(match_cnt), 32'd1);
    send(1'b1); send(1'b0); send(1'b1);
    nrst     = 1'b0;
    in_valid = 1'b1;
    in       = 1'b1;
    tick();
    nrst     = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_fill", 32'(fill), 32'd0);
    chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
    send(1'b1); chk("mid_rst_next", 32'(out), 32'd0);
    send(1'b0); send(1'b1);
    send(1'b1); chk("rst_default_cfg", 32'(out), 32'd1);

    // len 0 disables detection, fill still counts
    load(8'b0000_0000, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      send(1'b0);
      chk("len0_out", 32'(out), 32'd0);
    end
    chk("len0_fill", 32'(fill), 32'd8);
    chk("len0_cnt", 32'(match_cnt), 32'd0);

    // oversize len clamps to MAX_LEN
    load(8'b1011_0011, 4'd11, 1'b1, 1'b0);
    seq8 = 8'b1011_0011;
    for (int i = 7; i >= 0; i--) begin
      send(seq8[i]);
      chk("len8_out", 32'(out), 32'((i == 0) ? 1 : 0));
    end
    chk("len8_fill", 32'(fill), 32'd8);
    send(1'b0);
    chk("len8_after", 32'(out), 32'd0);
    chk("len8_fillsat", 32'(fill), 32'd8);
    chk("len8_cnt", 32'(match_cnt), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
